// File: rtl/adder_mul_sequencer.sv
// Purpose: 64x64 shift-add multiplier that drives one 64-bit ripple adder through 64 iterations and returns a 128-bit product.
// Latency: the request is accepted at edge E0, and done pulses after E64 (or after E65 when a signed result needs negating).
// Backpressure: ready is low while a multiply is in flight, and start is ignored until ready returns (no queueing).
//
// Optional feature: define MUL_SIGNED_EN to add the mul_signed port and two's-complement mode.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start, a, b           request strobe and operands; a and b are captured on acceptance
//   mul_signed            signed-mode select (only with MUL_SIGNED_EN)
//   ready, busy, done     idle / in-flight / one-cycle result-valid pulse
//   product_hi/lo        128-bit product, held until the next accepted request
//   hi_nonzero            the product does not fit in 64 bits

// Team 64-bit ripple-carry adder: sum = a + b + cin.
// The overflow output is signed overflow (carry into the MSB xor carry out of the MSB).
module sixtyfourbitadder (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        overflow
);
  logic [64:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 64; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = carry[64];
  assign overflow = carry[64] ^ carry[63];
endmodule

module adder_mul_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
`ifdef MUL_SIGNED_EN
  input  logic        mul_signed,
`endif
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] product_hi,
  output logic [63:0] product_lo,
  output logic        hi_nonzero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [63:0] acc;
  logic [63:0] mq;
  logic [63:0] mcand;
  logic [5:0]  cnt;
  logic        neg;

  logic [63:0] a_load;
  logic [63:0] b_load;
  logic [63:0] add_b;
  logic [63:0] add_sum;
  logic        add_cout;
  logic        unused_ovf;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign add_b = mq[0] ? mcand : 64'd0;

  sixtyfourbitadder u_adder (
    .a        (acc),
    .b        (add_b),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (unused_ovf)
  );

`ifdef MUL_SIGNED_EN
  // Signed mode multiplies the magnitudes and fixes the sign at the end.
  // The magnitude of 0x8000...0 is 0x8000...0 itself, which is correct when
  // it is read as unsigned.
  logic sgn_mode;

  assign a_load = (mul_signed && a[63]) ? (~a + 64'd1) : a;
  assign b_load = (mul_signed && b[63]) ? (~b + 64'd1) : b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg      <= 1'b0;
      sgn_mode <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      neg      <= mul_signed & (a[63] ^ b[63]);
      sgn_mode <= mul_signed;
    end
  end

  // In signed mode the result fits in 64 bits only if the high half is the
  // sign extension of the low half.
  assign hi_nonzero = sgn_mode ? (acc != {64{mq[63]}}) : (acc != 64'd0);
`else
  assign a_load     = a;
  assign b_load     = b;
  assign neg        = 1'b0;
  assign hi_nonzero = (acc != 64'd0);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (cnt == 6'd63) begin
`ifdef MUL_SIGNED_EN
          state_nxt = neg ? ST_NEG : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      ST_NEG:  state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_RUN:  busy  = 1'b1;
      ST_NEG:  busy  = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath. The adder carry-out becomes the new acc[63], so the 129-bit
  // {cout, sum, mq} is shifted right by one without losing any bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= '0;
            mq    <= b_load;
            mcand <= a_load;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          {acc, mq} <= {add_cout, add_sum, mq[63:1]};
          cnt       <= cnt + 6'd1;
        end
`ifdef MUL_SIGNED_EN
        ST_NEG: begin
          {acc, mq} <= ~{acc, mq} + 128'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign product_hi = acc;
  assign product_lo = mq;

endmodule

// File: tb/tb_adder_mul_sequencer.sv
module tb_adder_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
`ifdef MUL_SIGNED_EN
  logic        mul_signed = 1'b0;
`endif
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product_hi;
  logic [63:0] product_lo;
  logic        hi_nonzero;

  int tests = 0;
  int fails = 0;
  int lat;
  int bcnt;
  int dcnt;

  always #5 clk = ~clk;

  adder_mul_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef MUL_SIGNED_EN
    .mul_signed (mul_signed),
`endif
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo),
    .hi_nonzero (hi_nonzero)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; the request is accepted at the next edge (E0),
  // and the task returns #1 after E0.
  task automatic issue(input logic [63:0] av, input logic [63:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts the edges from E0 until done is seen and the samples with busy high.
  task automatic wait_done(output int n, output int busy_cnt);
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", product_hi, 0);
    check("rst_lo", product_lo, 0);
    check("rst_hnz", hi_nonzero, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 3 x 5
    issue(64'd3, 64'd5);
    wait_done(lat, bcnt);
    check("t1_latency", lat, 64);
    check("t1_busy_cycles", bcnt, 64);
    check("t1_hi", product_hi, 0);
    check("t1_lo", product_lo, 64'hF);
    check("t1_hnz", hi_nonzero, 0);
    @(posedge clk);
    #1;
    check("t1_done_one_cycle", done, 0);
    check("t1_ready_back", ready, 1);
    check("t1_hold_lo", product_lo, 64'hF);

    // All ones squared: carry out must reach acc[63]
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(lat, bcnt);
    check("t2_latency", lat, 64);
    check("t2_hi", product_hi, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t2_lo", product_lo, 64'h1);
    check("t2_hnz", hi_nonzero, 1);
    @(posedge clk);
    #1;

    // A start during RUN is ignored
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd2);
    repeat (10) @(posedge clk);
    #1;
    a     = 64'd1;
    b     = 64'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("t3_latency", lat, 64 - 11);
    check("t3_hi", product_hi, 0);
    check("t3_lo", product_lo, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t3_hnz", hi_nonzero, 0);
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("t3_extra_done", dcnt, 0);
    check("t3_hold_lo", product_lo, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t3_idle", ready, 1);

    // Reset in the middle of a multiply
    issue(64'h1_2345_6789, 64'h1_2345_6789);
    repeat (30) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("t4_ready", ready, 1);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_hi", product_hi, 0);
    check("t4_lo", product_lo, 0);
    check("t4_hnz", hi_nonzero, 0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(64'd3, 64'd5);
    wait_done(lat, bcnt);
    check("t4_latency", lat, 64);
    check("t4_lo_after", product_lo, 64'hF);
    check("t4_hi_after", product_hi, 0);
    @(posedge clk);
    #1;

`ifdef MUL_SIGNED_EN
    // -3 x 5 in signed mode goes through NEG
    mul_signed = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    wait_done(lat, bcnt);
    check("s1_latency", lat, 65);
    check("s1_busy_cycles", bcnt, 65);
    check("s1_hi", product_hi, 64'hFFFF_FFFF_FFFF_FFFF);
    check("s1_lo", product_lo, 64'hFFFF_FFFF_FFFF_FFF1);
    check("s1_hnz", hi_nonzero, 0);
    @(posedge clk);
    #1;

    // MIN x MIN: both magnitudes stay 0x8000...0 and no negation is needed
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    wait_done(lat, bcnt);
    check("s2_latency", lat, 64);
    check("s2_hi", product_hi, 64'h4000_0000_0000_0000);
    check("s2_lo", product_lo, 0);
    check("s2_hnz", hi_nonzero, 1);
    @(posedge clk);
    #1;
    mul_signed = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
